// File: rtl/dm_result_checker_if.sv
// Bus bundle for dm_result_checker: CPU-DM write-bus snoop plus the read-only check port
// shared by the data memory and the golden ROM.
interface dm_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  // Snoop side is observe-only: a transfer is any cycle with snp_enable high, with no back-pressure.
  // Check port is strobe/fixed-latency: mem_rd_en with mem_addr in cycle N returns dm_rd_data and
  // gold_rd_data in cycle N+1, and there is no ready. The memories must accept a read every cycle.
  logic              snp_enable;
  logic              snp_write;
  logic [ADDR_W-1:0] snp_address;
  logic [DATA_W-1:0] snp_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] dm_rd_data;
  logic [DATA_W-1:0] gold_rd_data;

  modport master (
    input  snp_enable, snp_write, snp_address, snp_data,
    input  dm_rd_data, gold_rd_data,
    output mem_rd_en, mem_addr
  );

  modport slave (
    output snp_enable, snp_write, snp_address, snp_data,
    output dm_rd_data, gold_rd_data,
    input  mem_rd_en, mem_addr
  );
endinterface

// File: rtl/dm_result_checker.sv
// End-of-test monitor: waits for the finish-flag store, then scans a DM region against a golden ROM.
// Optional macro DYN_LEN_EN: the scan length comes from the first DM word of the region (2*word+1).
module dm_result_checker #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] FLAG_ADDR  = 16'hFFFF,
  parameter logic [DATA_W-1:0] FLAG_VALUE = 32'hFFFF_F000,
  parameter logic [ADDR_W-1:0] CHECK_BASE = '0,
  parameter int                CHECK_LEN  = 32,
  parameter int                MAX_LEN    = 4096,
  parameter int                MAX_CYCLES = 10000000,
  parameter int                ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  dm_result_checker_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [2:0]           dbg_state
);

  localparam int LEN_STATIC = (CHECK_LEN < MAX_LEN) ? CHECK_LEN : MAX_LEN;
  localparam int LEN_W      = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);
  localparam int CYC_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef DYN_LEN_EN
  localparam logic [2:0] S_LEN_RD = 3'd5;
  localparam logic [2:0] S_LEN_WT = 3'd6;
`endif

  logic [2:0]        state, state_n;
  logic [LEN_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  len;
  logic [CYC_W-1:0]  cyc;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] dm_word, gold_word;
  logic              flag_hit;
  logic              mismatch;
  logic              scan_last;
  logic              wd_expire;
  logic [ERR_W-1:0]  err_n;

  assign dm_word   = bus.dm_rd_data;
  assign gold_word = bus.gold_rd_data;

  assign flag_hit  = bus.snp_enable && bus.snp_write &&
                     (bus.snp_address == FLAG_ADDR) && (bus.snp_data == FLAG_VALUE);
  assign mismatch  = cmp_valid && (dm_word != gold_word);
  assign scan_last = (idx == len - LEN_W'(1));
  assign wd_expire = (cyc == CYC_W'(MAX_CYCLES - 1));
  assign err_n     = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;

`ifdef DYN_LEN_EN
  // Length word is read in LEN_RD and lands in LEN_WT; 2*word+1 computed one bit wider to avoid overflow.
  logic [DATA_W:0]  dyn_raw;
  logic [LEN_W-1:0] dyn_len;
  logic [LEN_W-1:0] len_q;

  assign dyn_raw = {dm_word, 1'b1};
  assign len     = len_q;

  always_comb begin
    dyn_len = LEN_W'(dyn_raw);
    if (dyn_raw > (DATA_W + 1)'(MAX_LEN)) begin
      dyn_len = LEN_W'(MAX_LEN);
    end
  end
`else
  assign len = LEN_W'(LEN_STATIC);
`endif

  assign busy      = (state == S_ARMED) || (state == S_SCAN) || (state == S_DRAIN)
`ifdef DYN_LEN_EN
                     || (state == S_LEN_RD) || (state == S_LEN_WT)
`endif
                     ;
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = S_ARMED;
      end
      S_ARMED: begin
        // A flag arriving in the watchdog's last cycle still counts as completion.
        if (flag_hit) begin
          idx_n = '0;
`ifdef DYN_LEN_EN
          state_n = S_LEN_RD;
`else
          state_n = (len == '0) ? S_DONE : S_SCAN;
`endif
        end else if (wd_expire) begin
          state_n = S_DONE;
        end
      end
`ifdef DYN_LEN_EN
      S_LEN_RD: state_n = S_LEN_WT;
      S_LEN_WT: state_n = (dyn_len == '0) ? S_DONE : S_SCAN;
`endif
      S_SCAN: begin
        if (scan_last) state_n = S_DRAIN;
        else           idx_n   = idx + LEN_W'(1);
      end
      S_DRAIN: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cyc            <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_addr   <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
`ifdef DYN_LEN_EN
      len_q          <= LEN_W'(LEN_STATIC);
`endif
    end else begin
      state <= state_n;
      idx   <= idx_n;

      // Read port is registered off the next state so the strobe lines up with SCAN cycles.
      bus.mem_rd_en <= (state_n == S_SCAN);
      if (state_n == S_SCAN) bus.mem_addr <= CHECK_BASE + ADDR_W'(idx_n);
`ifdef DYN_LEN_EN
      if (state_n == S_LEN_RD) begin
        bus.mem_rd_en <= 1'b1;
        bus.mem_addr  <= CHECK_BASE;
      end
      if (state == S_LEN_WT) len_q <= dyn_len;
`endif

      cmp_valid <= (state == S_SCAN);
      cmp_addr  <= bus.mem_addr;
      err_count <= err_n;
      if (mismatch && (err_count == '0)) first_err_addr <= cmp_addr;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            cyc            <= '0;
          end
        end
        S_ARMED: begin
          cyc <= cyc + CYC_W'(1);
          if (!flag_hit && wd_expire) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (flag_hit && (state_n == S_DONE)) begin
            pass <= 1'b1;
          end
        end
`ifdef DYN_LEN_EN
        S_LEN_WT: begin
          if (state_n == S_DONE) pass <= 1'b1;
        end
`endif
        S_DRAIN: pass <= (err_n == '0);
        default: ;
      endcase
    end
  end

endmodule
